// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types for the arbiter request queue front end.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Numbering matches the arbiter's A/B/C state encoding.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_C    = 2'd3
    } src_e;

    localparam int NUM_CH = 3;

endpackage
`default_nettype wire

// File: rtl/arb_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_queue_if
// Description : Push channels, arbiter request/grant lines and popped-word bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_req_queue_if #(
    parameter int DW = 8
);
    import arb_pkg::*;

    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          c_valid;
    logic [DW-1:0] c_data;
    logic          c_ready;

    logic          a_req;
    logic          b_req;
    logic          c_req;
    logic          a_gnt;
    logic          b_gnt;
    logic          c_gnt;

    logic          out_valid;
    logic [DW-1:0] out_data;
    src_e          out_src;
    logic          gnt_err;

    modport master (
        output a_valid, a_data, b_valid, b_data, c_valid, c_data,
        output a_gnt, b_gnt, c_gnt,
        input  a_ready, b_ready, c_ready, a_req, b_req, c_req,
        input  out_valid, out_data, out_src, gnt_err
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, c_valid, c_data,
        input  a_gnt, b_gnt, c_gnt,
        output a_ready, b_ready, c_ready, a_req, b_req, c_req,
        output out_valid, out_data, out_src, gnt_err
    );

endinterface
`default_nettype wire

// File: rtl/arb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_fifo
// Description : Per-channel job FIFO, registered storage, combinational head.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  wire           clk,
    input  wire           rst,
    input  wire           i_push,
    input  wire  [DW-1:0] i_push_data,
    input  wire           i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [DW-1:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is not reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_queue
// Description : Request-side front end for the 3-way priority arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_queue
    import arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  wire             clk,
    input  wire             rst,
    arb_req_queue_if.slave  bus
);

    logic [NUM_CH-1:0] w_valid;
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_eg;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [DW-1:0]     w_push_data [NUM_CH];
    logic [DW-1:0]     w_head      [NUM_CH];
    logic [DW-1:0]     w_pop_data;
    src_e              w_src;
    logic              w_multi;
    logic              w_err;

    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    src_e              r_out_src;
    logic              r_gnt_err;

    assign w_valid        = {bus.c_valid, bus.b_valid, bus.a_valid};
    assign w_gnt          = {bus.c_gnt, bus.b_gnt, bus.a_gnt};
    assign w_push_data[0] = bus.a_data;
    assign w_push_data[1] = bus.b_data;
    assign w_push_data[2] = bus.c_data;

    assign w_ready = ~w_full;
    assign w_req   = ~w_empty;
    assign w_push  = w_valid & w_ready;
    assign w_eg    = w_gnt & w_req;

    assign bus.a_ready = w_ready[0];
    assign bus.b_ready = w_ready[1];
    assign bus.c_ready = w_ready[2];
    assign bus.a_req   = w_req[0];
    assign bus.b_req   = w_req[1];
    assign bus.c_req   = w_req[2];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
        arb_req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_push      (w_push[gi]),
            .i_push_data (w_push_data[gi]),
            .i_pop       (w_pop[gi]),
            .o_head      (w_head[gi]),
            .o_full      (w_full[gi]),
            .o_empty     (w_empty[gi])
        );
    end

    // Fixed A > B > C resolution; a well-behaved arbiter never grants two at once.
    always_comb begin
        w_pop      = '0;
        w_src      = SRC_NONE;
        w_pop_data = '0;
        if (w_eg[0]) begin
            w_pop      = 3'b001;
            w_src      = SRC_A;
            w_pop_data = w_head[0];
        end else if (w_eg[1]) begin
            w_pop      = 3'b010;
            w_src      = SRC_B;
            w_pop_data = w_head[1];
        end else if (w_eg[2]) begin
            w_pop      = 3'b100;
            w_src      = SRC_C;
            w_pop_data = w_head[2];
        end
    end

    assign w_multi = (w_eg[0] & w_eg[1]) | (w_eg[0] & w_eg[2]) | (w_eg[1] & w_eg[2]);
    assign w_err   = (|(w_gnt & ~w_req)) | w_multi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= SRC_NONE;
            r_gnt_err   <= 1'b0;
        end else begin
            r_out_valid <= |w_eg;
            r_out_src   <= w_src;
            if (|w_eg) begin
                r_out_data <= w_pop_data;
            end
            if (w_err) begin
                r_gnt_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.gnt_err   = r_gnt_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_req_queue
// Description : Self-checking bench for arb_req_queue against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_req_queue;
    import arb_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef logic [7:0] byteq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    arb_req_queue_if #(.DW(DW)) bus ();

    arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per channel plus expected output register.
    byteq_t     mq [3];
    logic       m_valid;
    logic [7:0] m_data;
    logic [1:0] m_src;
    logic       m_err;

    function automatic logic [2:0] m_req();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [2:0] m_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() != DEPTH);
        return r;
    endfunction

    task automatic idle_inputs();
        {bus.c_valid, bus.b_valid, bus.a_valid} = 3'b000;
        bus.a_data = '0; bus.b_data = '0; bus.c_data = '0;
        {bus.c_gnt, bus.b_gnt, bus.a_gnt} = 3'b000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_valid = 1'b0; m_data = '0; m_src = 2'd0; m_err = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, return at posedge+1.
    task automatic cycle(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [2:0] g);
        logic [2:0] req, rdy, eg;
        logic [7:0] d [3];
        int win;
        d[0] = d0; d[1] = d1; d[2] = d2;
        req = m_req();
        rdy = m_ready();
        {bus.c_valid, bus.b_valid, bus.a_valid} = v;
        bus.a_data = d0; bus.b_data = d1; bus.c_data = d2;
        {bus.c_gnt, bus.b_gnt, bus.a_gnt} = g;
        eg  = g & req;
        win = -1;
        for (int i = 2; i >= 0; i--) if (eg[i]) win = i;
        @(posedge clk); #1;
        if (((g & ~req) != 3'b000) || ($countones(eg) > 1)) m_err = 1'b1;
        m_valid = (win >= 0);
        m_src   = (win >= 0) ? 2'(win + 1) : 2'd0;
        if (win >= 0) m_data = mq[win].pop_front();
        for (int i = 0; i < 3; i++) if (v[i] && rdy[i]) mq[i].push_back(d[i]);
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        cycle(3'b111, 8'hA1, 8'hB1, 8'hC1, 3'b000);
        cycle(3'b001, 8'hA2, 8'h00, 8'h00, 3'b000);
        do_reset();
        n_checks++;
        if ({bus.c_req, bus.b_req, bus.a_req} !== 3'b000) begin
            n_errors++; $display("FAIL reset_req: got %b want 000", {bus.c_req, bus.b_req, bus.a_req});
        end
        n_checks++;
        if ({bus.c_ready, bus.b_ready, bus.a_ready} !== 3'b111) begin
            n_errors++; $display("FAIL reset_ready: got %b want 111", {bus.c_ready, bus.b_ready, bus.a_ready});
        end
        n_checks++;
        if ({bus.out_valid, bus.out_src, bus.gnt_err, bus.out_data} !== {1'b0, 2'd0, 1'b0, 8'h00}) begin
            n_errors++; $display("FAIL reset_out: valid/src/err/data got %b/%0d/%b/%h want 0/0/0/00",
                                 bus.out_valid, bus.out_src, bus.gnt_err, bus.out_data);
        end
        cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
        n_checks++;
        if (bus.out_valid !== 1'b0 || {bus.c_req, bus.b_req, bus.a_req} !== 3'b000) begin
            n_errors++; $display("FAIL reset_discard: valid=%b req=%b want 0/000",
                                 bus.out_valid, {bus.c_req, bus.b_req, bus.a_req});
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(3'b001, 8'(8'h11 + i), 8'h00, 8'h00, 3'b000);
            n_checks++;
            if (bus.a_ready !== (i < 3) || bus.a_req !== 1'b1) begin
                n_errors++; $display("FAIL fill_ready%0d: ready/req got %b/%b want %b/1",
                                     i, bus.a_ready, bus.a_req, (i < 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b001);
            n_checks++;
            if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, 2'd1, 8'(8'h11 + i)}) begin
                n_errors++; $display("FAIL fill_pop%0d: valid/src/data got %b/%0d/%h want 1/1/%h",
                                     i, bus.out_valid, bus.out_src, bus.out_data, 8'(8'h11 + i));
            end
        end
        n_checks++;
        if (bus.a_req !== 1'b0 || bus.gnt_err !== 1'b0) begin
            n_errors++; $display("FAIL fill_drained: a_req/gnt_err got %b/%b want 0/0", bus.a_req, bus.gnt_err);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cycle(3'b010, 8'h00, 8'(8'h20 + i), 8'h00, 3'b000);
            n_checks++;
            if (bus.b_req !== 1'b1 || bus.b_ready !== 1'b1) begin
                n_errors++; $display("FAIL wrap_push%0d: b_req/b_ready got %b/%b want 1/1", i, bus.b_req, bus.b_ready);
            end
            cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b010);
            n_checks++;
            if ({bus.out_valid, bus.out_src, bus.out_data, bus.b_req} !== {1'b1, 2'd2, 8'(8'h20 + i), 1'b0}) begin
                n_errors++; $display("FAIL wrap_pop%0d: valid/src/data/req got %b/%0d/%h/%b want 1/2/%h/0",
                                     i, bus.out_valid, bus.out_src, bus.out_data, bus.b_req, 8'(8'h20 + i));
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h30;
        cycle(3'b010, 8'h00, 8'h31, 8'h00, 3'b000);
        cycle(3'b010, 8'h00, 8'h32, 8'h00, 3'b000);
        cycle(3'b010, 8'h00, 8'h30, 8'h00, 3'b010);
        n_checks++;
        if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, 2'd2, exp_b[0]}) begin
            n_errors++; $display("FAIL simul_b_pop: valid/src/data got %b/%0d/%h want 1/2/31",
                                 bus.out_valid, bus.out_src, bus.out_data);
        end
        for (int i = 1; i < 3; i++) begin
            cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b010);
            n_checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, exp_b[i]}) begin
                n_errors++; $display("FAIL simul_b_drain%0d: valid/data got %b/%h want 1/%h",
                                     i, bus.out_valid, bus.out_data, exp_b[i]);
            end
        end
        for (int i = 0; i < 4; i++) cycle(3'b001, 8'(8'h41 + i), 8'h00, 8'h00, 3'b000);
        cycle(3'b001, 8'h45, 8'h00, 8'h00, 3'b001);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.a_ready} !== {1'b1, 8'h41, 1'b1}) begin
            n_errors++; $display("FAIL simul_full: valid/data/a_ready got %b/%h/%b want 1/41/1",
                                 bus.out_valid, bus.out_data, bus.a_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b001);
            n_checks++;
            if (bus.out_data !== 8'(8'h42 + i)) begin
                n_errors++; $display("FAIL simul_full_drain%0d: data got %h want %h", i, bus.out_data, 8'(8'h42 + i));
            end
        end
        n_checks++;
        if (bus.a_req !== 1'b0 || bus.gnt_err !== 1'b0) begin
            n_errors++; $display("FAIL simul_refused: a_req/gnt_err got %b/%b want 0/0", bus.a_req, bus.gnt_err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b100);
        n_checks++;
        if ({bus.out_valid, bus.gnt_err} !== 2'b01) begin
            n_errors++; $display("FAIL err_empty: valid/gnt_err got %b/%b want 0/1", bus.out_valid, bus.gnt_err);
        end
        cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
        n_checks++;
        if (bus.gnt_err !== 1'b1) begin
            n_errors++; $display("FAIL err_sticky: gnt_err got %b want 1", bus.gnt_err);
        end
        do_reset();
        cycle(3'b011, 8'h51, 8'h52, 8'h00, 3'b000);
        cycle(3'b000, 8'h00, 8'h00, 8'h00, 3'b011);
        n_checks++;
        if ({bus.out_valid, bus.out_src, bus.out_data, bus.gnt_err, bus.b_req} !== {1'b1, 2'd1, 8'h51, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL err_multi: valid/src/data/err/b_req got %b/%0d/%h/%b/%b want 1/1/51/1/1",
                                 bus.out_valid, bus.out_src, bus.out_data, bus.gnt_err, bus.b_req);
        end
        cycle(3'b100, 8'h00, 8'h00, 8'h53, 3'b100);
        n_checks++;
        if ({bus.out_valid, bus.out_src, bus.out_data, bus.c_req} !== {1'b0, 2'd0, 8'h51, 1'b1}) begin
            n_errors++; $display("FAIL err_push_empty: valid/src/data/c_req got %b/%0d/%h/%b want 0/0/51/1",
                                 bus.out_valid, bus.out_src, bus.out_data, bus.c_req);
        end
    endtask

    task automatic test_system();
        logic [2:0] g;
        logic [1:0] exp_src [4];
        logic [7:0] exp_dat [4];
        int got;
        exp_src[0] = 2'd1; exp_src[1] = 2'd1; exp_src[2] = 2'd2; exp_src[3] = 2'd3;
        exp_dat[0] = 8'h61; exp_dat[1] = 8'h62; exp_dat[2] = 8'h71; exp_dat[3] = 8'h81;
        do_reset();
        cycle(3'b111, 8'h61, 8'h71, 8'h81, 3'b000);
        cycle(3'b001, 8'h62, 8'h00, 8'h00, 3'b000);
        got = 0;
        for (int t = 0; t < 12 && got < 4; t++) begin
            g = bus.a_req ? 3'b001 : bus.b_req ? 3'b010 : bus.c_req ? 3'b100 : 3'b000;
            cycle(3'b000, 8'h00, 8'h00, 8'h00, g);
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (bus.out_src !== exp_src[got] || bus.out_data !== exp_dat[got]) begin
                    n_errors++; $display("FAIL sys_order%0d: src/data got %0d/%h want %0d/%h",
                                         got, bus.out_src, bus.out_data, exp_src[got], exp_dat[got]);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4 || bus.gnt_err !== 1'b0) begin
            n_errors++; $display("FAIL sys_count: pops/gnt_err got %0d/%b want 4/0", got, bus.gnt_err);
        end
    endtask

    task automatic test_random();
        logic [2:0] g;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if (t % 100 == 99) do_reset();
            g = ($urandom_range(0, 9) < 8) ? 3'(1 << $urandom_range(0, 3)) : 3'($urandom);
            cycle(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), g);
            n_checks++;
            if ({bus.out_valid, bus.out_src, bus.out_data, bus.gnt_err} !== {m_valid, m_src, m_data, m_err} ||
                {bus.c_req, bus.b_req, bus.a_req, bus.c_ready, bus.b_ready, bus.a_ready} !== {m_req(), m_ready()}) begin
                n_errors++;
                $display("FAIL random%0d: v/src/data/err/req/rdy got %b/%0d/%h/%b/%b/%b want %b/%0d/%h/%b/%b/%b", t,
                         bus.out_valid, bus.out_src, bus.out_data, bus.gnt_err,
                         {bus.c_req, bus.b_req, bus.a_req}, {bus.c_ready, bus.b_ready, bus.a_ready},
                         m_valid, m_src, m_data, m_err, m_req(), m_ready());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_system();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
